reg_bank_read_port: RTL and testbench

REG_BANK_READ_PORT -- requirements
Module: reg_bank_read_port

---
 rtl/reg_bank_read_port.sv | 118 +++++++++++
 tb/tb_reg_bank_read_port.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_read_port.sv
// rtl/reg_bank_read_port.sv - register bank with a ready/valid read port and write-to-read bypass
module reg_bank_read_port #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write_enable,
    input  logic [AW-1:0] write_addr,
    input  logic [N-1:0]  data_in,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_req_ready,
    output logic [N-1:0]  data_out,
    output logic          data_valid,
    input  logic          data_ready,
    output logic [7:0]    rd_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_bank [DEPTH];
    logic [N-1:0]   r_data_out;
    logic [7:0]     r_rd_count;
    logic           w_accept;
    logic           w_xfer;
    logic [N-1:0]   w_rd_data;

    assign w_accept = rd_req && rd_req_ready;
    assign w_xfer   = data_valid && data_ready;

    // A write landing on the address being read this edge wins, so the read sees the new value
    assign w_rd_data = (write_enable && (write_addr == rd_addr)) ? data_in : r_bank[rd_addr];

    assign data_out = r_data_out;
    assign rd_count = r_rd_count;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: an acceptance always leads to RESP; otherwise a completed transfer drains to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_RESP;
            S_RESP: begin
                if (w_accept) begin
                    w_next_state = S_RESP;
                end else if (w_xfer) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs: ready passes consumer ready through in RESP so a new request can replace the old response
    always_comb begin
        rd_req_ready = 1'b1;
        data_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                rd_req_ready = 1'b1;
                data_valid   = 1'b0;
            end
            S_RESP: begin
                rd_req_ready = data_ready;
                data_valid   = 1'b1;
            end
            default: begin
                rd_req_ready = 1'b1;
                data_valid   = 1'b0;
            end
        endcase
    end

    // Register bank write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (write_enable) begin
            r_bank[write_addr] <= data_in;
        end
    end

    // Response data snapshot: only updated on acceptance, so it holds through stalls and in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_accept) begin
            r_data_out <= w_rd_data;
        end
    end

    // Completed-transfer counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
        end else if (w_xfer) begin
            r_rd_count <= r_rd_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_reg_bank_read_port.sv
// tb/tb_reg_bank_read_port.sv - scoreboard bench for reg_bank_read_port
module tb_reg_bank_read_port;

    logic       clk;
    logic       rst_n;
    logic       write_enable;
    logic [2:0] write_addr;
    logic [7:0] data_in;
    logic       rd_req;
    logic [2:0] rd_addr;
    logic       rd_req_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] rd_count;

    int         checks;
    int         errors;
    logic [7:0] sb [$];

    reg_bank_read_port #(.N(8), .DEPTH(8), .AW(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .data_in      (data_in),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_req_ready (rd_req_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .rd_count     (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response transfer is compared against the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got 0x%0h expected none", data_out);
            end else begin
                chk("resp_data", {24'd0, data_out}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        write_enable = 1'b1;
        write_addr   = a;
        data_in      = d;
        @(posedge clk); #1;
        write_enable = 1'b0;
    endtask

    task automatic issue(input logic [2:0] a, input logic [7:0] exp, input bit push);
        int n;
        rd_req  = 1'b1;
        rd_addr = a;
        n = 0;
        @(negedge clk);
        while (!rd_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rd_req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
        end else if (push) begin
            sb.push_back(exp);
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        write_enable = 1'b0;
        write_addr   = '0;
        data_in      = '0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        data_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_count", {24'd0, rd_count}, 32'd0);
        chk("rst_ready", {31'd0, rd_req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First read after reset returns zero with one-cycle latency
        issue(3'd3, 8'h00, 1);
        chk("first_valid", {31'd0, data_valid}, 32'd1);
        drain();
        chk("count_1", {24'd0, rd_count}, 32'd1);

        // Plain write then read, and same-edge write/read bypass
        wr(3'd2, 8'hA5);
        issue(3'd2, 8'hA5, 1);
        drain();
        write_enable = 1'b1;
        write_addr   = 3'd5;
        data_in      = 8'h3C;
        issue(3'd5, 8'h3C, 1);
        write_enable = 1'b0;
        drain();
        chk("count_3", {24'd0, rd_count}, 32'd3);

        // Stall: response snapshot holds while its source is overwritten; requests ignored
        data_ready = 1'b0;
        issue(3'd2, 8'hA5, 1);
        for (int i = 0; i < 4; i++) begin
            write_enable = 1'b1;
            write_addr   = 3'd2;
            data_in      = 8'hFF;
            rd_req       = 1'b1;
            rd_addr      = 3'd4;
            @(negedge clk);
            chk("stall_ready", {31'd0, rd_req_ready}, 32'd0);
            chk("stall_valid", {31'd0, data_valid}, 32'd1);
            chk("stall_data", {24'd0, data_out}, 32'h0000_00A5);
            @(posedge clk); #1;
        end
        write_enable = 1'b0;
        rd_req       = 1'b0;
        data_ready   = 1'b1;
        drain();
        chk("count_4", {24'd0, rd_count}, 32'd4);
        issue(3'd2, 8'hFF, 1);
        drain();

        // Back-to-back burst over all addresses: one response per cycle, no bubbles
        for (int i = 0; i < 8; i++) wr(i[2:0], 8'h10 + i[7:0]);
        for (int i = 0; i < 8; i++) begin
            rd_req  = 1'b1;
            rd_addr = i[2:0];
            @(negedge clk);
            chk("b2b_ready", {31'd0, rd_req_ready}, 32'd1);
            if (i > 0) chk("b2b_valid", {31'd0, data_valid}, 32'd1);
            sb.push_back(8'h10 + i[7:0]);
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        drain();
        chk("count_13", {24'd0, rd_count}, 32'd13);
        chk("idle_valid", {31'd0, data_valid}, 32'd0);
        chk("idle_hold", {24'd0, data_out}, 32'h0000_0017);

        // Run the counter up to 256 completed transfers so it wraps to zero
        for (int i = 0; i < 243; i++) begin
            rd_req  = 1'b1;
            rd_addr = i[2:0];
            sb.push_back(8'h10 + {5'd0, i[2:0]});
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        drain();
        chk("count_wrap", {24'd0, rd_count}, 32'd0);

        // Asynchronous reset while a response is pending
        data_ready = 1'b0;
        issue(3'd1, 8'h11, 0);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, data_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, data_valid}, 32'd0);
        chk("arst_data", {24'd0, data_out}, 32'd0);
        chk("arst_count", {24'd0, rd_count}, 32'd0);
        chk("arst_ready", {31'd0, rd_req_ready}, 32'd1);
        write_enable = 1'b1;
        write_addr   = 3'd6;
        data_in      = 8'h77;
        @(posedge clk); #1;
        write_enable = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        data_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) issue(i[2:0], 8'h00, 1);
        drain();
        chk("post_rst_count", {24'd0, rd_count}, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
